// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and constants for the MIPS32 pipeline.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StBuf   = 2'd1,
    StDrain = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, pc+4 and valid, with flush over load.
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS32 instruction-fetch stage: PC, imem handshake, stall buffer and redirect drain.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic        ifid_valid_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  buf_instr_q, buf_instr_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        ifid_load;
  logic        ifid_flush;
  logic [31:0] ifid_instr_in;

  assign redirect = (branch_valid_i | jump_i) & ~stall_i;
  assign target   = branch_valid_i ? branch_target_i : jump_target_i;
  assign pc_plus4 = pc_q + INSTR_BYTES;

  // The address of an outstanding request must not move, so a redirect
  // mid-wait parks the old address in drain_addr until the response returns.
  assign imem_req_o  = ~reset_i & (state_q != StBuf);
  assign imem_addr_o = (state_q == StDrain) ? drain_addr_q : pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    buf_instr_d   = buf_instr_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_instr_in = imem_rdata_i;
    unique case (state_q)
      StRun: begin
        if (redirect) begin
          pc_d       = target;
          ifid_flush = 1'b1;
          if (!imem_ready_i) begin
            drain_addr_d = pc_q;
            state_d      = StDrain;
          end
        end else if (imem_ready_i && !stall_i) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
        end else if (imem_ready_i) begin
          buf_instr_d = imem_rdata_i;
          state_d     = StBuf;
        end
      end
      StBuf: begin
        if (!stall_i) begin
          state_d = StRun;
          if (redirect) begin
            pc_d       = target;
            ifid_flush = 1'b1;
          end else begin
            ifid_load     = 1'b1;
            ifid_instr_in = buf_instr_q;
            pc_d          = pc_plus4;
          end
        end
      end
      StDrain: begin
        if (redirect) begin
          pc_d       = target;
          ifid_flush = 1'b1;
        end else if (imem_ready_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      buf_instr_q  <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_instr_q  <= buf_instr_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .instr_i    (ifid_instr_in),
    .pc_plus4_i (pc_plus4),
    .instr_o    (ifid_instr_o),
    .pc_plus4_o (ifid_pc_plus4_o),
    .valid_o    (ifid_valid_o)
  );

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the MIPS32 pipeline. Owns the PC, drives the instruction-memory request/ready handshake and loads the IF/ID pipeline register. It consumes the ID-stage branch decision (`branch_valid`, target) and the jump redirect, and flushes the wrong-path instruction. There is no branch delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `stall`  in  1  hazard-unit hold of PC and IF/ID; redirects are ignored while high
- `branch_valid`  in  1  ID comparator: taken branch this cycle
- `branch_target`  in  32  branch destination address
- `jump`  in  1  ID decode: jump this cycle
- `jump_target`  in  32  jump destination address
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; stable while `imem_req & !imem_ready`
- `imem_rdata`  in  32  instruction; valid in the cycle `imem_ready=1`
- `imem_ready`  in  1  request accepted and data returned (zero or more wait cycles)
- `ifid_instr`  out  32  IF/ID instruction; NOP (32'h0) when invalid
- `ifid_pc_plus4`  out  32  address of `ifid_instr` + 4
- `ifid_valid`  out  1  IF/ID holds a live instruction

## Operation
- `redirect = (branch_valid | jump) & !stall`. The target is `branch_target` if `branch_valid`, else `jump_target`; branch wins if both are set.
- Registers: `pc`, `drain_addr`, 1-entry `buf_instr`, FSM state, IF/ID fields.
- States:
  - RUN: `imem_req=1`, `imem_addr=pc`.
  - BUF: a fetched instruction is held because of `stall`; `imem_req=0`.
  - DRAIN: a stale request is outstanding; `imem_req=1`, `imem_addr=drain_addr`, and the response is discarded.
- RUN transitions:
  - redirect: `pc<=target` and flush IF/ID. If `imem_ready` is high, drop the data and stay in RUN. Otherwise latch `drain_addr<=pc` and go to DRAIN.
  - `imem_ready & !stall`: IF/ID <= {rdata, pc+4, 1} and `pc<=pc+4`.
  - `imem_ready & stall`: `buf_instr<=rdata` and go to BUF. `pc` and IF/ID hold.
  - Otherwise hold.
- BUF transitions:
  - `stall`: hold.
  - redirect: drop the buffer, `pc<=target`, flush IF/ID, go to RUN.
  - Else: IF/ID <= {buf_instr, pc+4, 1}, `pc<=pc+4`, go to RUN.
- DRAIN transitions:
  - redirect: `pc<=target`, flush IF/ID, stay in DRAIN (`drain_addr` unchanged).
  - `imem_ready`: drop the data, go to RUN.
- Flush sets `ifid_valid<=0`, `ifid_instr<=0`, `ifid_pc_plus4<=0`. Flush has priority over load.
- In RUN/DRAIN, `stall` with no redirect leaves IF/ID unchanged.
- PC arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.
- Targets are used as given; bits [1:0] are not checked.

## Timing
- Reset (`reset=1` at an edge): `pc=RESET_PC`, state RUN, `ifid_*=0`, `buf_instr=0`. `imem_req=0` combinationally while `reset=1`. Reset overrides every in-flight state, including DRAIN and BUF.
- Zero-wait memory: instruction at address A appears on IF/ID one cycle after `imem_addr=A`. Sustained throughput is 1 instruction/cycle.
- Redirect penalty: 1 bubble with zero-wait memory, plus any remaining wait cycles of a drained request.
- `imem_addr` must never change while `imem_req & !imem_ready`. DRAIN exists to meet this rule.
- No instruction is lost or duplicated across any stall pattern.

## Structure
- Shared pipeline package holds:
  - the `fetch_state_t` enum {RUN, BUF, DRAIN}
  - `NOP_INSTR = 32'h0000_0000`
  - `INSTR_BYTES = 4`
- One sub-module, `if_id_reg`: a 3-field register with `load`, `flush` (priority) and sync reset. The FSM, PC and buffer stay in the top.

## Test plan
- Reset release, `imem_ready=1`, mem[A]=A|0xA000_0000 -> IF/ID shows pc_plus4 4, 8, 12 on consecutive cycles, each with `ifid_valid=1`.
- `stall=1` for 3 cycles while `imem_ready=1` at pc 0x8 -> enters BUF with `imem_req=0` and IF/ID frozen. One cycle after release, instr@0x8 with pc_plus4 0xC; no skip, no duplicate.
- At pc 0x10, `branch_valid=1`, target 0x40 -> next cycle `ifid_valid=0`, `imem_addr=0x40`. The following cycle has instr@0x40, pc_plus4 0x44.
- `imem_ready=0` for 2 cycles at pc 0x20, `jump=1` to 0x100 in the first wait cycle -> `imem_addr` stays 0x20 until ready, the response is dropped, then `imem_addr=0x100` and instr@0x100 is the next valid.
- `branch_valid=1` (0x40) and `jump=1` (0x80) in the same cycle -> fetch from 0x40. The same pair with `stall=1` is ignored.
- `reset=1` during DRAIN -> next cycle `pc=RESET_PC`, state RUN, `ifid_valid=0`; the stale response is never loaded.
